// File: rtl/i2c_target.sv
// I2C target with an internal byte register file: oversampled SCL/SDA, 7-bit address match,
// pointer-based writes and auto-incrementing reads.
module i2c_target #(
  parameter logic [6:0] ADDR   = 7'h10,
  parameter int         REG_AW = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_sda_oe,
  output logic              o_wr_stb,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [7:0]        o_dbg_data,
  output logic              o_busy
);

  // state    | meaning
  // IDLE     | bus ignored until START
  // ADDR     | shifting address byte (7 bits + R/W)
  // ADDR_ACK | driving address ACK
  // PTR      | receiving register pointer
  // PTR_ACK  | driving pointer ACK
  // RX       | receiving data byte
  // RX_ACK   | driving data ACK (write happens on entry)
  // TX       | shifting out regs[ptr]
  // TX_ACK   | SDA released, sampling master ACK/NACK
  // WAIT     | SDA released until STOP or START
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
  } state_t;

  localparam int NREG = 1 << REG_AW;

  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_s, sda_d;
  logic scl_rise, scl_fall, ev_start, ev_stop;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [7:0]        sh, sh_nxt;
  logic [REG_AW-1:0] ptr, ptr_nxt;
  logic              rw, rw_nxt;
  logic              m_ack, m_ack_nxt;
  logic              sda_oe, sda_oe_nxt;
  logic              busy, busy_nxt;
  logic              wr_stb, wr_stb_nxt;
  logic [REG_AW-1:0] wr_addr, wr_addr_nxt;
  logic [7:0]        wr_data, wr_data_nxt;
  logic              we;
  logic [7:0]        rd_byte;
  logic [7:0]        regs [NREG];

  // Sync flops reset to the idle-bus level so release from reset creates no events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= i_scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= i_sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign ev_start = scl_s & scl_d & sda_d & ~sda_s;
  assign ev_stop  = scl_s & scl_d & ~sda_d & sda_s;

  assign rd_byte = regs[ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sh      <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      m_ack   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      m_ack   <= m_ack_nxt;
      sda_oe  <= sda_oe_nxt;
      busy    <= busy_nxt;
      wr_stb  <= wr_stb_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_nxt      = sh;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    m_ack_nxt   = m_ack;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    wr_stb_nxt  = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    we          = 1'b0;

    if (ev_stop) begin
      state_nxt  = S_IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (ev_start) begin
      state_nxt  = S_ADDR;
      cnt_nxt    = '0;
      sda_oe_nxt = 1'b0;
    end else if (scl_rise) begin
      case (state)
        S_ADDR, S_PTR, S_RX: begin
          sh_nxt  = {sh[6:0], sda_s};
          cnt_nxt = cnt + 4'd1;
        end
        S_TX:     cnt_nxt = cnt + 4'd1;
        S_TX_ACK: m_ack_nxt = ~sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      // All SDA drive changes happen here, while SCL is low.
      case (state)
        S_ADDR: begin
          if (cnt == 4'd8) begin
            if (sh[7:1] == ADDR) begin
              state_nxt  = S_ADDR_ACK;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              rw_nxt     = sh[0];
            end else begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          cnt_nxt = '0;
          if (rw) begin
            state_nxt  = S_TX;
            sh_nxt     = rd_byte;
            sda_oe_nxt = ~rd_byte[7];
          end else begin
            state_nxt  = S_PTR;
            sda_oe_nxt = 1'b0;
          end
        end
        S_PTR: begin
          if (cnt == 4'd8) begin
            state_nxt  = S_PTR_ACK;
            ptr_nxt    = sh[REG_AW-1:0];
            sda_oe_nxt = 1'b1;
          end
        end
        S_PTR_ACK, S_RX_ACK: begin
          state_nxt  = S_RX;
          cnt_nxt    = '0;
          sda_oe_nxt = 1'b0;
        end
        S_RX: begin
          if (cnt == 4'd8) begin
            state_nxt   = S_RX_ACK;
            we          = 1'b1;
            wr_stb_nxt  = 1'b1;
            wr_addr_nxt = ptr;
            wr_data_nxt = sh;
            sda_oe_nxt  = 1'b1;
            ptr_nxt     = ptr + REG_AW'(1);
          end
        end
        S_TX: begin
          if (cnt == 4'd8) begin
            state_nxt  = S_TX_ACK;
            sda_oe_nxt = 1'b0;
            ptr_nxt    = ptr + REG_AW'(1);
          end else begin
            sh_nxt     = {sh[6:0], 1'b0};
            sda_oe_nxt = ~sh[6];
          end
        end
        S_TX_ACK: begin
          if (m_ack) begin
            state_nxt  = S_TX;
            cnt_nxt    = '0;
            sh_nxt     = rd_byte;
            sda_oe_nxt = ~rd_byte[7];
          end else begin
            state_nxt = S_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[ptr] <= sh;
    end
  end

  assign o_sda_oe   = sda_oe;
  assign o_wr_stb   = wr_stb;
  assign o_wr_addr  = wr_addr;
  assign o_wr_data  = wr_data;
  assign o_busy     = busy;
  assign o_dbg_data = regs[i_dbg_addr];

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-level I2C master with a wired-AND SDA bus,
// a write-strobe scoreboard and a read-data scoreboard.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] dbg_addr = '0;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, dbg_data;
  logic       sda_bus;

  int checks = 0;
  int errors = 0;
  int oe_cycles = 0;

  typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.ADDR(7'h10), .REG_AW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl_m), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (sda_oe) oe_cycles++;

  // Write-strobe scoreboard
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      logic have;
      wr_t  e;
      have = (wq.size() != 0);
      checks++;
      assert (have === 1'b1) else begin
        errors++;
        $error("FAIL wr_unexpected observed (%0d,%02h) expected no strobe", wr_addr, wr_data);
      end
      if (have) begin
        e = wq.pop_front();
        checks++;
        assert ({wr_addr, wr_data} === {e.a, e.d}) else begin
          errors++;
          $error("FAIL wr_stb observed (%0d,%02h) expected (%0d,%02h)", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; q();
    scl_m = 1'b1; q();
    s = sda_bus; q();
    scl_m = 1'b0; q();
  endtask

  task automatic wb(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    chk(tag, {31'd0, ~s}, {31'd0, exp_ack});
  endtask

  task automatic rb(input logic mack, input string tag);
    logic [7:0] b;
    logic       s;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~mack, s);
    e = rq.pop_front();
    chk(tag, {24'd0, b}, {24'd0, e});
  endtask

  task automatic dbg(input logic [3:0] a, input logic [7:0] e, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, e});
  endtask

  initial begin
    logic s;
    int   oe0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy",   {31'd0, busy},   0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 0);
    dbg(4'd0, 8'h00, "rst_dbg0");
    rst_n = 1'b1;
    q();

    // Seed reg 5 so the pointer position after the read test is observable
    wq.push_back('{a: 4'd5, d: 8'hC3});
    i2c_start(); wb(8'h20, 1, "seed_addr"); wb(8'h05, 1, "seed_ptr"); wb(8'hC3, 1, "seed_data"); i2c_stop();

    // Write 0xA5, 0x5A at pointer 3
    wq.push_back('{a: 4'd3, d: 8'hA5});
    wq.push_back('{a: 4'd4, d: 8'h5A});
    i2c_start();
    wb(8'h20, 1, "w_addr_ack");
    chk("w_busy_hi", {31'd0, busy}, 1);
    wb(8'h03, 1, "w_ptr_ack");
    wb(8'hA5, 1, "w_d0_ack");
    wb(8'h5A, 1, "w_d1_ack");
    i2c_stop(); q();
    chk("w_busy_lo", {31'd0, busy}, 0);
    dbg(4'd3, 8'hA5, "w_dbg3");
    dbg(4'd4, 8'h5A, "w_dbg4");

    // Pointer write, repeated START, read two bytes
    i2c_start(); wb(8'h20, 1, "r_addr_w"); wb(8'h03, 1, "r_ptr");
    i2c_rstart(); wb(8'h21, 1, "r_addr_r");
    rq.push_back(8'hA5); rb(1'b1, "r_byte0");
    rq.push_back(8'h5A); rb(1'b0, "r_byte1");
    chk("r_released", {31'd0, sda_oe}, 0);
    i2c_stop();

    // Pointer must now sit at 5
    i2c_start(); wb(8'h21, 1, "p5_addr");
    rq.push_back(8'hC3); rb(1'b0, "p5_byte");
    i2c_stop();

    // Wrong address: NACK, no drive, no strobes, busy low
    oe0 = oe_cycles;
    i2c_start();
    wb(8'h22, 0, "na_addr_nack");
    chk("na_busy0", {31'd0, busy}, 0);
    wb(8'hFF, 0, "na_data_nack");
    chk("na_busy1", {31'd0, busy}, 0);
    i2c_stop();
    chk("na_no_oe", oe_cycles, oe0);

    // Pointer wrap on writes
    wq.push_back('{a: 4'd15, d: 8'h11});
    wq.push_back('{a: 4'd0,  d: 8'h22});
    i2c_start(); wb(8'h20, 1, "wr_addr"); wb(8'h0F, 1, "wr_ptr");
    wb(8'h11, 1, "wr_d0"); wb(8'h22, 1, "wr_d1"); i2c_stop();
    dbg(4'd15, 8'h11, "wr_dbg15");
    dbg(4'd0,  8'h22, "wr_dbg0");

    // STOP after 4 bits of a data byte
    i2c_start(); wb(8'h20, 1, "ps_addr"); wb(8'h07, 1, "ps_ptr");
    for (int i = 7; i >= 4; i--) clock_bit(i[0], s);
    i2c_stop(); q();
    chk("ps_sda_oe", {31'd0, sda_oe}, 0);
    chk("ps_busy",   {31'd0, busy},   0);
    chk("ps_no_wr",  wq.size(), 0);
    dbg(4'd7, 8'h00, "ps_dbg7");
    wq.push_back('{a: 4'd7, d: 8'h99});
    i2c_start(); wb(8'h20, 1, "ps2_addr"); wb(8'h07, 1, "ps2_ptr"); wb(8'h99, 1, "ps2_data"); i2c_stop();
    dbg(4'd7, 8'h99, "ps2_dbg7");

    // Reset while driving a 0 bit in TX
    i2c_start(); wb(8'h20, 1, "rt_addr_w"); wb(8'h04, 1, "rt_ptr");
    i2c_rstart(); wb(8'h21, 1, "rt_addr_r");
    chk("rt_drive_low", {31'd0, sda_oe}, 1);
    #2 rst_n = 1'b0;
    #1 chk("rt_async_oe", {31'd0, sda_oe}, 0);
    chk("rt_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 16; i++) dbg(i[3:0], 8'h00, "rt_dbg_clear");
    scl_m = 1'b1; sda_m = 1'b1;
    q();
    rst_n = 1'b1;
    q();
    wq.push_back('{a: 4'd2, d: 8'h77});
    i2c_start(); wb(8'h20, 1, "fr_addr"); wb(8'h02, 1, "fr_ptr"); wb(8'h77, 1, "fr_data"); i2c_stop();
    i2c_start(); wb(8'h20, 1, "fr_addr_w"); wb(8'h02, 1, "fr_ptr2");
    i2c_rstart(); wb(8'h21, 1, "fr_addr_r");
    rq.push_back(8'h77); rb(1'b0, "fr_read");
    i2c_stop(); q();

    chk("wq_drained", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
